// File: rtl/rmap_status_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : rmap_status_monitor_if
// Purpose  : Bundles the status inputs of NUM_CH RMAP targets, the register
//            read port, first-error capture and interrupt of the monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface rmap_status_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [NUM_CH-1:0]   write_ind;
  logic [NUM_CH-1:0]   read_ind;
  logic [NUM_CH-1:0]   rmw_ind;
  logic [NUM_CH-1:0]   err_ind;
  logic [8*NUM_CH-1:0] err_code;
  logic [NUM_CH-1:0]   addr_invalid;
  logic [NUM_CH-1:0]   len_invalid;
  logic [NUM_CH-1:0]   clr;
  logic [NUM_CH-1:0]   irq_mask;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_valid;
  logic                first_err_valid;
  logic [3:0]          first_err_ch;
  logic [7:0]          first_err_code;
  logic                first_err_clr;
  logic                irq;

  // Host / stimulus side
  modport master (
    output write_ind, read_ind, rmw_ind, err_ind, err_code,
    output addr_invalid, len_invalid, clr, irq_mask,
    output rd_en, rd_addr, first_err_clr,
    input  rd_data, rd_valid, first_err_valid, first_err_ch, first_err_code, irq
  );

  // Monitor side
  modport slave (
    input  write_ind, read_ind, rmw_ind, err_ind, err_code,
    input  addr_invalid, len_invalid, clr, irq_mask,
    input  rd_en, rd_addr, first_err_clr,
    output rd_data, rd_valid, first_err_valid, first_err_ch, first_err_code, irq
  );
endinterface
`default_nettype wire

// File: rtl/rmap_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rmap_status_monitor
// Purpose  : Per-channel transaction/error counters, sticky flags, last error
//            code and first-error capture for NUM_CH RMAP targets, with a
//            one-cycle register read port and a maskable interrupt.
// Option   : RMAP_STAT_SATURATE_EN - counters saturate at all-ones instead of
//            wrapping to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rmap_status_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rmap_status_monitor_if.slave bus
);
  localparam int AW = $clog2(NUM_CH) + 3;

  // Indication index: 0 wr, 1 rd, 2 rmw, 3 err, 4 addr_invalid, 5 len_invalid
  logic [5:0][NUM_CH-1:0] w_raw;
  logic [5:0][NUM_CH-1:0] r_smp;
  logic [5:0][NUM_CH-1:0] r_prv;
  logic [5:0][NUM_CH-1:0] w_ev;
  logic [8*NUM_CH-1:0]    r_code;
  logic                   r_armed;

  logic [CNT_W-1:0]       w_word [NUM_CH];
  logic [NUM_CH-1:0]      w_irq_src;

  assign w_raw = {bus.len_invalid, bus.addr_invalid, bus.err_ind,
                  bus.rmw_ind, bus.read_ind, bus.write_ind};

  // Sample indications; the first edge after reset loads both stages so inputs already high are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp   <= '0;
      r_prv   <= '0;
      r_code  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_smp   <= w_raw;
      r_code  <= bus.err_code;
      r_armed <= 1'b1;
      r_prv   <= r_armed ? r_smp : w_raw;
    end
  end

  assign w_ev = r_smp & ~r_prv;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [4:0]       w_cev;
    logic [CNT_W-1:0] r_cnt [5];
    logic [CNT_W-1:0] w_nxt [5];
    logic [3:0]       r_sticky;
    logic [3:0]       w_sticky_nxt;
    logic [7:0]       r_lastcode;
    logic             w_ovf;
    logic [CNT_W-1:0] w_word_c;

    // AUTH counts once even when both authentication errors rise together
    assign w_cev = {w_ev[4][c] | w_ev[5][c], w_ev[3][c], w_ev[2][c], w_ev[1][c], w_ev[0][c]};

    // Next counter values: a clear is applied first, then this cycle's event
    always_comb begin
      w_ovf = 1'b0;
      for (int k = 0; k < 5; k++) begin
        w_nxt[k] = bus.clr[c] ? '0 : r_cnt[k];
        if (w_cev[k]) begin
          if (&w_nxt[k]) w_ovf = 1'b1;
`ifdef RMAP_STAT_SATURATE_EN
          if (!(&w_nxt[k])) w_nxt[k] = w_nxt[k] + CNT_W'(1);
`else
          w_nxt[k] = w_nxt[k] + CNT_W'(1);
`endif
        end
      end
    end

    assign w_sticky_nxt = (bus.clr[c] ? 4'b0000 : r_sticky)
                        | {w_ovf, w_ev[5][c], w_ev[4][c], w_ev[3][c]};

    // Counters, sticky flags and last error code of this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
        r_sticky   <= '0;
        r_lastcode <= '0;
      end else begin
        for (int k = 0; k < 5; k++) r_cnt[k] <= w_nxt[k];
        r_sticky <= w_sticky_nxt;
        if (w_ev[3][c]) r_lastcode <= r_code[8*c +: 8];
      end
    end

    // Register-map word of this channel for the current select
    always_comb begin
      w_word_c = '0;
      case (bus.rd_addr[2:0])
        3'd0:    w_word_c = r_cnt[0];
        3'd1:    w_word_c = r_cnt[1];
        3'd2:    w_word_c = r_cnt[2];
        3'd3:    w_word_c = r_cnt[3];
        3'd4:    w_word_c = r_cnt[4];
        3'd5:    w_word_c = CNT_W'({r_lastcode, r_sticky});
        default: w_word_c = '0;
      endcase
    end

    assign w_word[c]    = w_word_c;
    // Overflow (bit3) deliberately does not feed the interrupt
    assign w_irq_src[c] = (|r_sticky[2:0]) & bus.irq_mask[c];
  end

  logic [AW-1:0]    w_addr_ch;
  logic [CNT_W-1:0] w_rd_mux;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_valid;

  assign w_addr_ch = bus.rd_addr >> 3;

  // Channel select; an index beyond NUM_CH matches nothing and reads 0
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_addr_ch == AW'(c)) w_rd_mux = w_word[c];
    end
  end

  // Read port: data holds until the next read, valid is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_mux;
    end
  end

  logic       w_any_err;
  logic [3:0] w_fe_ch;
  logic [7:0] w_fe_code;
  logic       r_fe_valid;
  logic [3:0] r_fe_ch;
  logic [7:0] r_fe_code;

  // Lowest-index channel with an error event this cycle
  always_comb begin
    w_any_err = |w_ev[3];
    w_fe_ch   = '0;
    w_fe_code = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_ev[3][c]) begin
        w_fe_ch   = 4'(c);
        w_fe_code = r_code[8*c +: 8];
      end
    end
  end

  // First-error capture; a new capture wins over a simultaneous re-arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_valid <= 1'b0;
      r_fe_ch    <= '0;
      r_fe_code  <= '0;
    end else if ((!r_fe_valid || bus.first_err_clr) && w_any_err) begin
      r_fe_valid <= 1'b1;
      r_fe_ch    <= w_fe_ch;
      r_fe_code  <= w_fe_code;
    end else if (bus.first_err_clr) begin
      r_fe_valid <= 1'b0;
    end
  end

  logic r_irq;

  // Registered interrupt from masked sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |w_irq_src;
  end

  assign bus.rd_data         = r_rd_data;
  assign bus.rd_valid        = r_rd_valid;
  assign bus.first_err_valid = r_fe_valid;
  assign bus.first_err_ch    = r_fe_ch;
  assign bus.first_err_code  = r_fe_code;
  assign bus.irq             = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_rmap_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmap_status_monitor
// Purpose  : Self-checking bench for rmap_status_monitor with a behavioural
//            reference model of counters, flags, first-error and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmap_status_monitor;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(NUM_CH) + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rmap_status_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  rmap_status_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [CNT_W-1:0]    m_cnt [NUM_CH][5];
  logic [3:0]          m_sticky [NUM_CH];
  logic [7:0]          m_last [NUM_CH];
  logic                m_fvalid;
  logic [3:0]          m_fch;
  logic [7:0]          m_fcode;
  logic                m_irq;
  logic                m_armed;
  logic [NUM_CH-1:0]   m_prev [6];
  logic [NUM_CH-1:0]   m_pend [6];
  logic [8*NUM_CH-1:0] m_pend_code;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 5; k++) m_cnt[c][k] = '0;
      m_sticky[c] = '0;
      m_last[c]   = '0;
    end
    for (int k = 0; k < 6; k++) begin
      m_prev[k] = '0;
      m_pend[k] = '0;
    end
    m_pend_code = '0;
    m_fvalid = 1'b0; m_fch = '0; m_fcode = '0; m_irq = 1'b0; m_armed = 1'b0;
  endtask

  // One clock edge: events seen on the previous edge are applied (after any clear),
  // then this edge's samples become the next pending events.
  task automatic model_step();
    logic [NUM_CH-1:0] smp [6];
    logic irq_n;
    logic ev;
    int   hit;
    irq_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if ((m_sticky[c][2:0] != 3'b000) && bus.irq_mask[c]) irq_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.clr[c]) begin
        for (int k = 0; k < 5; k++) m_cnt[c][k] = '0;
        m_sticky[c] = '0;
      end
      for (int k = 0; k < 5; k++) begin
        ev = (k < 4) ? m_pend[k][c] : (m_pend[4][c] | m_pend[5][c]);
        if (ev) begin
          if (m_cnt[c][k] == {CNT_W{1'b1}}) begin
            m_sticky[c][3] = 1'b1;
`ifndef RMAP_STAT_SATURATE_EN
            m_cnt[c][k] = '0;
`endif
          end else begin
            m_cnt[c][k] = m_cnt[c][k] + 1'b1;
          end
        end
      end
      if (m_pend[3][c]) begin
        m_last[c] = m_pend_code[8*c +: 8];
        m_sticky[c][0] = 1'b1;
      end
      if (m_pend[4][c]) m_sticky[c][1] = 1'b1;
      if (m_pend[5][c]) m_sticky[c][2] = 1'b1;
    end
    hit = -1;
    for (int c = 0; c < NUM_CH; c++) if (m_pend[3][c] && hit < 0) hit = c;
    if (hit >= 0 && (!m_fvalid || bus.first_err_clr)) begin
      m_fvalid = 1'b1;
      m_fch    = 4'(hit);
      m_fcode  = m_pend_code[8*hit +: 8];
    end else if (bus.first_err_clr) begin
      m_fvalid = 1'b0;
    end
    m_irq = irq_n;
    smp = '{bus.write_ind, bus.read_ind, bus.rmw_ind, bus.err_ind, bus.addr_invalid, bus.len_invalid};
    for (int k = 0; k < 6; k++) begin
      m_pend[k] = m_armed ? (smp[k] & ~m_prev[k]) : '0;
      m_prev[k] = smp[k];
    end
    m_pend_code = bus.err_code;
    m_armed = 1'b1;
  endtask

  function automatic logic [CNT_W-1:0] model_word(int ch, int sel);
    if (sel <= 4) return m_cnt[ch][sel];
    if (sel == 5) return CNT_W'({m_last[ch], m_sticky[ch]});
    return '0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
  endtask

  task automatic drive_idle();
    bus.write_ind = '0; bus.read_ind = '0; bus.rmw_ind = '0; bus.err_ind = '0;
    bus.err_code = '0; bus.addr_invalid = '0; bus.len_invalid = '0; bus.clr = '0;
    bus.first_err_clr = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic do_read(input int ch, input int sel, output logic [CNT_W-1:0] d, output logic v);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'((ch << 3) | sel);
    tick();
    bus.rd_en = 1'b0;
    d = bus.rd_data;
    v = bus.rd_valid;
  endtask

  task automatic clear_all();
    bus.clr = '1; tick(); bus.clr = '0;
    bus.first_err_clr = 1'b1; tick(); bus.first_err_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [CNT_W-1:0] d, exp;
    logic v;
    drive_idle();
    bus.irq_mask = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", bus.irq); else n_pass++;
    n_checks++; if (bus.first_err_valid !== 1'b0) $display("FAIL reset_fev: got %b want 0", bus.first_err_valid); else n_pass++;
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) $display("FAIL reset_rd: got v=%b d=%h want 0/0", bus.rd_valid, bus.rd_data); else n_pass++;
    exp = '0;
    for (int s = 0; s < 8; s++) begin
      exp = model_word(0, s);
      do_read(0, s, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp) $display("FAIL reset_read sel%0d: got v=%b d=%h want v=1 d=%h", s, v, d, exp); else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp) $display("FAIL rd_valid_pulse: got v=%b d=%h want v=0 d=%h", bus.rd_valid, bus.rd_data, exp); else n_pass++;
  endtask

  task automatic test_write_burst();
    logic [CNT_W-1:0] d, exp;
    logic v;
    int hold [3] = '{1, 5, 1};
    for (int p = 0; p < 3; p++) begin
      bus.write_ind[2] = 1'b1; repeat (hold[p]) tick();
      bus.write_ind[2] = 1'b0; repeat (2) tick();
    end
    // Latency: a rise sampled at edge N is readable by a read issued at edge N+2
    bus.write_ind[1] = 1'b1; tick();
    bus.write_ind[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp = model_word(1, 0);
      do_read(1, 0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp) $display("FAIL wr_latency r%0d: got v=%b d=%h want %h", r, v, d, exp); else n_pass++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      exp = model_word(c, 0);
      do_read(c, 0, d, v);
      n_checks++;
      if (d !== exp) $display("FAIL wr_count ch%0d: got %h want %h", c, d, exp); else n_pass++;
    end
  endtask

  task automatic test_first_err();
    logic [CNT_W-1:0] d, exp;
    logic v;
    clear_all();
    bus.err_code = {8'h05, 8'h33, 8'h0A, 8'h77};
    bus.err_ind  = 4'b1010;
    tick(); tick();
    n_checks++;
    if (bus.first_err_valid !== m_fvalid || bus.first_err_ch !== m_fch || bus.first_err_code !== m_fcode)
      $display("FAIL first_err: got v=%b ch=%0d code=%h want v=%b ch=%0d code=%h", bus.first_err_valid, bus.first_err_ch, bus.first_err_code, m_fvalid, m_fch, m_fcode);
    else n_pass++;
    bus.err_ind = '0;
    tick();
    for (int c = 1; c < NUM_CH; c += 2) begin
      for (int s = 3; s <= 5; s += 2) begin
        exp = model_word(c, s);
        do_read(c, s, d, v);
        n_checks++;
        if (d !== exp) $display("FAIL err_regs ch%0d sel%0d: got %h want %h", c, s, d, exp); else n_pass++;
      end
    end
    // A later error does not overwrite the capture
    bus.err_code = {8'h00, 8'h44, 8'h00, 8'h00}; bus.err_ind = 4'b0100;
    tick(); tick(); bus.err_ind = '0;
    n_checks++;
    if (bus.first_err_ch !== m_fch || bus.first_err_code !== m_fcode) $display("FAIL first_err_hold: got ch=%0d code=%h want ch=%0d code=%h", bus.first_err_ch, bus.first_err_code, m_fch, m_fcode); else n_pass++;
    // Re-arm coincident with a new error: the new error is captured
    bus.err_code = {8'h00, 8'h00, 8'h00, 8'hC3}; bus.err_ind = 4'b0001;
    tick(); bus.first_err_clr = 1'b1; tick(); bus.first_err_clr = 1'b0; bus.err_ind = '0;
    n_checks++;
    if (bus.first_err_valid !== m_fvalid || bus.first_err_ch !== m_fch || bus.first_err_code !== m_fcode)
      $display("FAIL first_err_rearm: got v=%b ch=%0d code=%h want v=%b ch=%0d code=%h", bus.first_err_valid, bus.first_err_ch, bus.first_err_code, m_fvalid, m_fch, m_fcode);
    else n_pass++;
    bus.first_err_clr = 1'b1; tick(); bus.first_err_clr = 1'b0;
    n_checks++;
    if (bus.first_err_valid !== m_fvalid) $display("FAIL first_err_clr: got %b want %b", bus.first_err_valid, m_fvalid); else n_pass++;
  endtask

  task automatic test_irq();
    clear_all();
    bus.irq_mask = 4'b0010;
    bus.err_ind = 4'b1000; tick(); bus.err_ind = '0; repeat (3) tick();
    n_checks++; if (bus.irq !== m_irq) $display("FAIL irq_masked: got %b want %b", bus.irq, m_irq); else n_pass++;
    bus.addr_invalid = 4'b0010; tick(); bus.addr_invalid = '0; repeat (3) tick();
    n_checks++; if (bus.irq !== m_irq) $display("FAIL irq_enabled: got %b want %b", bus.irq, m_irq); else n_pass++;
    bus.clr = 4'b0010; tick(); bus.clr = '0;
    n_checks++; if (bus.irq !== m_irq) $display("FAIL irq_clr_latency: got %b want %b", bus.irq, m_irq); else n_pass++;
    tick();
    n_checks++; if (bus.irq !== m_irq) $display("FAIL irq_cleared: got %b want %b", bus.irq, m_irq); else n_pass++;
  endtask

  task automatic test_clr_coincident();
    logic [CNT_W-1:0] d, exp;
    logic v;
    for (int p = 0; p < 2; p++) begin
      bus.read_ind[0] = 1'b1; tick(); bus.read_ind[0] = 1'b0; tick();
    end
    tick();
    bus.read_ind[0] = 1'b1; tick();
    bus.clr[0] = 1'b1; tick(); bus.clr[0] = 1'b0; bus.read_ind[0] = 1'b0;
    exp = model_word(0, 1);
    do_read(0, 1, d, v);
    n_checks++; if (d !== exp) $display("FAIL clr_coincident: got %h want %h", d, exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [CNT_W-1:0] d, exp;
    logic v;
    bus.irq_mask = '1;
    bus.err_ind = 4'b0100; bus.write_ind = 4'b0001; tick(); tick();
    bus.err_ind = '0; tick();
    do_read(2, 3, d, v);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.irq !== 1'b0 || bus.first_err_valid !== 1'b0 || bus.rd_data !== '0)
      $display("FAIL async_reset: got irq=%b fev=%b rd=%h want 0", bus.irq, bus.first_err_valid, bus.rd_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // write_ind[0] is still high across reset release and must not count
    repeat (3) tick();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 8; s++) begin
        exp = model_word(c, s);
        do_read(c, s, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== exp) $display("FAIL post_reset ch%0d sel%0d: got v=%b d=%h want %h", c, s, v, d, exp); else n_pass++;
      end
    end
    bus.write_ind = '0; tick();
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] d, exp;
    logic v;
    for (int i = 0; i < 400; i++) begin
      bus.write_ind    ^= NUM_CH'($urandom & $urandom);
      bus.read_ind     ^= NUM_CH'($urandom & $urandom);
      bus.rmw_ind      ^= NUM_CH'($urandom & $urandom);
      bus.err_ind      ^= NUM_CH'($urandom & $urandom & $urandom);
      bus.addr_invalid ^= NUM_CH'($urandom & $urandom & $urandom);
      bus.len_invalid  ^= NUM_CH'($urandom & $urandom & $urandom);
      bus.err_code      = (8*NUM_CH)'($urandom);
      bus.clr           = NUM_CH'($urandom & $urandom & $urandom & $urandom);
      bus.first_err_clr = ($urandom_range(0, 7) == 0);
      if (i % 50 == 0) bus.irq_mask = NUM_CH'($urandom);
      tick();
      n_checks++;
      if (bus.irq !== m_irq) $display("FAIL rand_irq cyc%0d: got %b want %b", i, bus.irq, m_irq); else n_pass++;
      n_checks++;
      if (bus.first_err_valid !== m_fvalid || (m_fvalid && (bus.first_err_ch !== m_fch || bus.first_err_code !== m_fcode)))
        $display("FAIL rand_first_err cyc%0d: got v=%b ch=%0d code=%h want v=%b ch=%0d code=%h", i, bus.first_err_valid, bus.first_err_ch, bus.first_err_code, m_fvalid, m_fch, m_fcode);
      else n_pass++;
    end
    drive_idle();
    repeat (2) tick();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 8; s++) begin
        exp = model_word(c, s);
        do_read(c, s, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== exp) $display("FAIL rand_read ch%0d sel%0d: got v=%b d=%h want %h", c, s, v, d, exp); else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] d, exp;
    logic v;
    clear_all();
    // Alternating addr/len rises give one AUTH event per cycle
    for (int i = 0; i < 65535; i++) begin
      bus.addr_invalid[0] = ~i[0];
      bus.len_invalid[0]  = i[0];
      tick();
    end
    bus.addr_invalid = '0; bus.len_invalid = '0;
    repeat (2) tick();
    for (int r = 0; r < 3; r++) begin
      exp = model_word(0, 4);
      do_read(0, 4, d, v);
      n_checks++; if (d !== exp) $display("FAIL ovf_auth step%0d: got %h want %h", r, d, exp); else n_pass++;
      exp = model_word(0, 5);
      do_read(0, 5, d, v);
      n_checks++; if (d !== exp) $display("FAIL ovf_flag step%0d: got %h want %h", r, d, exp); else n_pass++;
      bus.len_invalid[0] = 1'b1; tick(); bus.len_invalid[0] = 1'b0; repeat (2) tick();
    end
  endtask

  initial begin
    drive_idle();
    bus.irq_mask = '0;
    model_reset();
    test_reset();
    test_write_burst();
    test_first_err();
    test_irq();
    test_clr_coincident();
    test_reset_mid();
    test_random();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
